// File: rtl/sync_fifo_if.sv
// rtl/sync_fifo_if.sv - handshake bundle between a FIFO and its producer/consumer
//
// Purpose: groups the write/read request, data and status signals of
// sync_fifo so that both sides connect through one port.
// Signals:
//   din        write data, driven by master
//   wr_en      write request, driven by master
//   rd_en      read request / FWFT pop, driven by master
//   dout       read data, driven by slave
//   full       occupancy == DEPTH, driven by slave
//   empty      occupancy == 0, driven by slave
//   data_count occupancy 0..DEPTH, driven by slave
// Modports: master (producer/consumer side), slave (FIFO side).

interface sync_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4096
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] din;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic [CW-1:0]    data_count;

    modport master (
        output din,
        output wr_en,
        output rd_en,
        input  dout,
        input  full,
        input  empty,
        input  data_count
    );

    modport slave (
        input  din,
        input  wr_en,
        input  rd_en,
        output dout,
        output full,
        output empty,
        output data_count
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - parameterized single-clock FIFO with optional first-word-fall-through
//
// Purpose: DEPTH x WIDTH first-in first-out buffer sharing one clock between
// the write and read sides, exporting an exact registered occupancy count.
// Parameters:
//   WIDTH  data word width
//   DEPTH  number of words, power of two >= 2
//   FWFT   1 = oldest word presented on dout while not empty, rd_en pops it
//          0 = dout is a register loaded on each accepted read
// Ports:
//   clk    rising-edge clock
//   rstn   asynchronous active-low reset
//   bus    sync_fifo_if slave modport (din, wr_en, rd_en, dout, full,
//          empty, data_count)

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4096,
    parameter int FWFT  = 0
) (
    input  logic        clk,
    input  logic        rstn,
    sync_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Storage is not reset; only pointers and count define validity.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic full_w;
    logic empty_w;
    logic wr_acc;
    logic rd_acc;

    // Flags come straight from the registered count, so no request input
    // ever reaches a status output combinationally.
    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);

    // A write while full is dropped even if a read is accepted on the same
    // edge: the decision uses the pre-edge full flag only.
    assign wr_acc = bus.wr_en && !full_w;
    assign rd_acc = bus.rd_en && !empty_w;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= bus.din;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // The head word is read asynchronously from the array; a word
            // written at edge N is visible here once count_q turns non-zero.
            // Forcing zero while empty gives dout=0 out of reset.
            assign bus.dout = empty_w ? '0 : mem[rd_ptr_q];
        end else begin : g_std
            logic [WIDTH-1:0] dout_q;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    dout_q <= '0;
                end else if (rd_acc) begin
                    dout_q <= mem[rd_ptr_q];
                end
            end

            assign bus.dout = dout_q;
        end
    endgenerate

    assign bus.full       = full_w;
    assign bus.empty      = empty_w;
    assign bus.data_count = count_q;

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - self-checking bench for the three sync_fifo configurations

module tb_sync_fifo;
    localparam int D8   = 4096;
    localparam int D16  = 32;
    localparam int D144 = 256;

    logic clk;
    logic rstn;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_if #(.WIDTH(8),   .DEPTH(D8))   if8 ();
    sync_fifo_if #(.WIDTH(16),  .DEPTH(D16))  if16 ();
    sync_fifo_if #(.WIDTH(144), .DEPTH(D144)) if144 ();

    sync_fifo #(.WIDTH(8),   .DEPTH(D8),   .FWFT(0)) u8   (.clk(clk), .rstn(rstn), .bus(if8));
    sync_fifo #(.WIDTH(16),  .DEPTH(D16),  .FWFT(0)) u16  (.clk(clk), .rstn(rstn), .bus(if16));
    sync_fifo #(.WIDTH(144), .DEPTH(D144), .FWFT(1)) u144 (.clk(clk), .rstn(rstn), .bus(if144));

    // Reference model: one queue per FIFO plus the last popped word for the
    // registered-read configurations.
    logic [7:0]   q8[$];
    logic [15:0]  q16[$];
    logic [143:0] q144[$];
    logic [7:0]   m8_dout;
    logic [15:0]  m16_dout;
    bit           w8_acc;
    int           rd8_total;

    int total;
    int bad;

    task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("cnt8",  144'(if8.data_count), 144'(q8.size()));
        chk("emp8",  144'(if8.empty),      144'(q8.size() == 0));
        chk("ful8",  144'(if8.full),       144'(q8.size() == D8));
        chk("dout8", 144'(if8.dout),       144'(m8_dout));
        chk("cnt16",  144'(if16.data_count), 144'(q16.size()));
        chk("emp16",  144'(if16.empty),      144'(q16.size() == 0));
        chk("ful16",  144'(if16.full),       144'(q16.size() == D16));
        chk("dout16", 144'(if16.dout),       144'(m16_dout));
        chk("cnt144", 144'(if144.data_count), 144'(q144.size()));
        chk("emp144", 144'(if144.empty),      144'(q144.size() == 0));
        chk("ful144", 144'(if144.full),       144'(q144.size() == D144));
        if (q144.size() > 0) chk("dout144", if144.dout, q144[0]);
    endtask

    // One clock: model advances on the rising edge using the pre-edge
    // queue state, outputs are compared on the following falling edge.
    task automatic tick();
        bit wa, ra;
        @(posedge clk);
        wa = if8.wr_en && (q8.size() < D8);
        ra = if8.rd_en && (q8.size() > 0);
        w8_acc = wa;
        if (ra) begin m8_dout = q8.pop_front(); rd8_total++; end
        if (wa) q8.push_back(if8.din);
        wa = if16.wr_en && (q16.size() < D16);
        ra = if16.rd_en && (q16.size() > 0);
        if (ra) m16_dout = q16.pop_front();
        if (wa) q16.push_back(if16.din);
        wa = if144.wr_en && (q144.size() < D144);
        ra = if144.rd_en && (q144.size() > 0);
        if (ra) void'(q144.pop_front());
        if (wa) q144.push_back(if144.din);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_inputs();
        if8.wr_en = 0;   if8.rd_en = 0;   if8.din = '0;
        if16.wr_en = 0;  if16.rd_en = 0;  if16.din = '0;
        if144.wr_en = 0; if144.rd_en = 0; if144.din = '0;
    endtask

    task automatic clear_model();
        q8.delete(); q16.delete(); q144.delete();
        m8_dout = '0; m16_dout = '0;
    endtask

    task automatic check_reset_state();
        chk("rst_cnt8",   144'(if8.data_count), 144'(0));
        chk("rst_emp8",   144'(if8.empty),      144'(1));
        chk("rst_ful8",   144'(if8.full),       144'(0));
        chk("rst_dout8",  144'(if8.dout),       144'(0));
        chk("rst_cnt16",  144'(if16.data_count), 144'(0));
        chk("rst_dout16", 144'(if16.dout),      144'(0));
        chk("rst_emp144", 144'(if144.empty),    144'(1));
        chk("rst_dout144", if144.dout,          144'(0));
    endtask

    initial begin
        logic [143:0] pat_a;
        int written;
        int cyc;
        int phase;

        total = 0;
        bad = 0;
        rd8_total = 0;
        w8_acc = 0;
        clear_model();
        idle_inputs();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state();
        rstn = 1'b1;
        @(negedge clk);
        check_all();

        // Read while empty is ignored.
        if8.rd_en = 1;
        repeat (2) tick();
        chk("emptyrd_dout8", 144'(if8.dout), 144'(0));
        if8.rd_en = 0;

        // W16/D32: fill, drop a write at full, drain in order.
        for (int i = 1; i <= 32; i++) begin
            if16.wr_en = 1; if16.din = 16'(i);
            tick();
        end
        chk("w16_full", 144'(if16.full), 144'(1));
        if16.din = 16'hFFFF;
        tick();
        chk("w16_cnt_after_drop", 144'(if16.data_count), 144'(32));
        if16.wr_en = 0;
        for (int i = 1; i <= 32; i++) begin
            if16.rd_en = 1;
            tick();
            chk("w16_order", 144'(if16.dout), 144'(i));
        end
        if16.rd_en = 0;
        tick();
        chk("w16_empty", 144'(if16.empty), 144'(1));

        // W144 FWFT: single word falls through, one pop empties it.
        pat_a = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
        if144.wr_en = 1; if144.din = pat_a;
        tick();
        if144.wr_en = 0;
        chk("fwft_dout", if144.dout, pat_a);
        chk("fwft_nempty", 144'(if144.empty), 144'(0));
        if144.rd_en = 1;
        tick();
        if144.rd_en = 0;
        chk("fwft_empty", 144'(if144.empty), 144'(1));
        chk("fwft_cnt", 144'(if144.data_count), 144'(0));

        // Simultaneous read and write at count 5, then at full.
        for (int i = 0; i < 5; i++) begin
            if16.wr_en = 1; if16.din = 16'($urandom);
            tick();
        end
        if16.rd_en = 1; if16.din = 16'h1234;
        tick();
        chk("wr_rd_cnt5", 144'(if16.data_count), 144'(5));
        if16.rd_en = 0;
        for (int i = 0; i < 27; i++) begin
            if16.din = 16'($urandom);
            tick();
        end
        chk("w16_full2", 144'(if16.full), 144'(1));
        if16.rd_en = 1; if16.din = 16'hBEEF;
        tick();
        chk("wr_rd_full", 144'(if16.data_count), 144'(D16 - 1));
        if16.wr_en = 0;
        for (int i = 0; i < D16 - 1; i++) tick();
        if16.rd_en = 0;
        tick();

        // W8/D4096 wrap: 10000 bytes through with bursty traffic.
        written = 0;
        cyc = 0;
        while (!(written == 10000 && q8.size() == 0) && cyc < 40000) begin
            phase = (cyc / 500) % 2;
            if8.din   = written[7:0];
            if8.wr_en = (written < 10000) && ($urandom_range(0, 9) < (phase != 0 ? 9 : 3));
            if8.rd_en = $urandom_range(0, 9) < (phase != 0 ? 3 : 9);
            tick();
            if (w8_acc) written++;
            if (if8.data_count > 13'(D8)) chk("cap8", 144'(if8.data_count), 144'(D8));
            cyc++;
        end
        idle_inputs();
        chk("wrap_reads", 144'(rd8_total), 144'(10000));
        chk("wrap_empty", 144'(if8.empty), 144'(1));

        // Reset mid-burst at count 100.
        for (int i = 0; i < 100; i++) begin
            if8.wr_en = 1; if8.din = 8'($urandom);
            tick();
        end
        chk("pre_rst_cnt", 144'(if8.data_count), 144'(100));
        #2;
        rstn = 1'b0;
        #1;
        idle_inputs();
        clear_model();
        check_reset_state();
        @(negedge clk);
        rstn = 1'b1;
        if8.wr_en = 1; if8.din = 8'hA5;
        tick();
        if8.wr_en = 0; if8.rd_en = 1;
        tick();
        if8.rd_en = 0;
        chk("post_rst_data", 144'(if8.dout), 144'(8'hA5));
        chk("post_rst_empty", 144'(if8.empty), 144'(1));
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parameterized single-clock FIFO used for all packet/pointer buffering in the switch output path. Three configurations are instantiated:
- a 144-bit × 256 first-word-fall-through cell buffer;
- a 16-bit × 32 frame-pointer queue;
- an 8-bit × 4096 byte-data queue.

Write and read sides share one clock. An occupancy count is exported so upstream logic can derive back-pressure thresholds.

## Interface
- WIDTH, 8, data word width in bits.
- DEPTH, 4096, number of storage words; must be a power of two ≥ 2.
- FWFT, 0, 1 = first-word-fall-through read mode; 0 = standard registered read.
- CW (localparam), log2(DEPTH)+1, width of data_count.

Standard configurations:
- WIDTH=144, DEPTH=256, FWFT=1
- WIDTH=16, DEPTH=32, FWFT=0
- WIDTH=8, DEPTH=4096, FWFT=0

Ports:
- clk  in  1  sole clock, rising edge.
- rstn  in  1  reset; one clock; reset is asynchronous and active-low.
- din  in  WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request (FWFT: acknowledge/pop of word on dout).
- dout  out  WIDTH  read data.
- full  out  1  high when data_count == DEPTH.
- empty  out  1  high when data_count == 0.
- data_count  out  CW  words stored (written, not yet popped), 0..DEPTH.

## Operation
- Storage: DEPTH-entry array, write pointer and read pointer of log2(DEPTH) bits, both wrapping modulo DEPTH naturally. Occupancy counter is CW bits.
- Write accepted iff wr_en && !full (full as registered before the edge). A write while full is silently dropped, even if a read is accepted the same cycle.
- Read accepted iff rd_en && !empty. A read while empty is ignored: no pointer change and no dout change.
- On the same edge:
  - write only: count +1
  - read only: count −1
  - both accepted: count unchanged
- Data order is strictly first-in first-out; no word is duplicated or lost across pointer wrap.
- Standard mode (FWFT=0):
  - dout is a register.
  - On an accepted read edge it loads the word at the read pointer.
  - Otherwise it holds its value.
- FWFT mode (FWFT=1):
  - While empty=0, dout continuously presents the oldest word, with no read needed.
  - An accepted rd_en pops it, and the next word is presented after that edge.
  - dout is don't-care while empty=1.
- full, empty and data_count derive only from the registered counter; no combinational path from wr_en/rd_en to any flag.
- Reset, asserted at any time including mid-transfer, immediately:
  - clears both pointers and the count
  - sets empty=1, full=0, data_count=0, dout=0
  - discards all contents
- Storage array itself need not be reset.

## Timing
- Write at edge N: data_count, empty and full reflect it from edge N onward, i.e. visible in cycle N+1.
- FWFT: a word written into an empty FIFO at edge N is on dout with empty=0 in cycle N+1 (one-cycle write-to-read latency).
- Standard mode: read accepted at edge N puts the word on dout in cycle N+1.
- Back-to-back reads and writes every cycle are sustained at full throughput.
- Upstream thresholds sample data_count registered; count is exact with no extra pipeline lag.

## Test plan
- Reset then idle (W8/D4096): empty=1, full=0, data_count=0, dout=0. Read with rd_en=1 while empty: all unchanged.
- W16/D32 standard: write 0x0001..0x0020 on 32 consecutive cycles.
  - Result: full=1, data_count=32. A 33rd write (0xFFFF) is dropped.
  - Read 32: dout 0x0001..0x0020 in order, each one cycle after its rd_en. Then empty=1.
- W144/D256 FWFT: single write of pattern A.
  - Next cycle: empty=0, dout=A, no rd_en.
  - Pulse rd_en: empty=1, data_count=0.
- Simultaneous wr/rd at count=5: count stays 5. At full with wr+rd: read pops, write dropped, count=DEPTH−1.
- Wrap: W8/D4096, write and read 10000 bytes of an incrementing pattern with interleaved bursts. Output matches input mod 256, and count never exceeds 4096.
- Assert rstn low mid-burst with count=100: immediately count=0, empty=1. After release, a new write/read returns only new data.
